// File: rtl/yaw_integrator.sv
// Yaw-rate integrator: calibrates the gyro zero-rate offset, then integrates the compensated rate into a 12-bit heading.
// Optional guardrail IR fusion is enabled by defining IR_FUSION_EN.
module yaw_integrator #(
    parameter int FAST_SIM    = 1,
    parameter int DEADBAND    = 4,
    parameter int FUSION_GAIN = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cal,
    input  logic        vld,
    input  logic [15:0] yaw_rt,
    input  logic        moving,
    input  logic        lftIR,
    input  logic        rghtIR,
    output logic        cal_done,
    output logic        rdy,
    output logic [11:0] heading
);

    localparam int CAL_N     = (FAST_SIM != 0) ? 256 : 2048;
    localparam int CAL_SHIFT = (FAST_SIM != 0) ? 8 : 11;
    localparam logic [11:0]        CAL_LAST = 12'(CAL_N - 1);
    localparam logic signed [16:0] DB_S     = 17'(DEADBAND);

    typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

    state_t             state_q, state_d;
    logic [11:0]        cal_cnt_q, cal_cnt_d;
    logic signed [26:0] cal_acc_q, cal_acc_d;
    logic signed [15:0] yaw_off_q, yaw_off_d;
    logic [26:0]        head_acc_q, head_acc_d;
    logic               cal_done_q, cal_done_d;
    logic               rdy_q, rdy_d;

    logic signed [16:0] comp_wide;
    logic signed [15:0] comp;
    logic signed [26:0] fuse;
    logic signed [26:0] cal_sum;

    // Offset-compensated rate, saturated to 16 bits, with small residuals squashed to zero
    always_comb begin
        comp_wide = {yaw_rt[15], yaw_rt} - {yaw_off_q[15], yaw_off_q};
        case (comp_wide[16:15])
            2'b01:   comp = 16'sh7FFF;
            2'b10:   comp = -16'sh8000;
            default: comp = comp_wide[15:0];
        endcase
        if ((comp_wide < DB_S) && (comp_wide > -DB_S)) begin
            comp = '0;
        end
    end

`ifdef IR_FUSION_EN
    always_comb begin
        fuse = '0;
        if (lftIR && !rghtIR) begin
            fuse = -27'(FUSION_GAIN);
        end else if (rghtIR && !lftIR) begin
            fuse = 27'(FUSION_GAIN);
        end
    end
`else
    logic unused_ir;
    assign unused_ir = &{1'b0, lftIR, rghtIR, FUSION_GAIN[0]};
    assign fuse      = '0;
`endif

    assign cal_sum = cal_acc_q + {{11{yaw_rt[15]}}, yaw_rt};

    always_comb begin
        state_d    = state_q;
        cal_cnt_d  = cal_cnt_q;
        cal_acc_d  = cal_acc_q;
        yaw_off_d  = yaw_off_q;
        head_acc_d = head_acc_q;
        cal_done_d = 1'b0;
        rdy_d      = 1'b0;
        // strt_cal wins over a coincident sample, which is simply dropped
        if (strt_cal) begin
            state_d   = CAL;
            cal_acc_d = '0;
            cal_cnt_d = '0;
        end else if (vld) begin
            case (state_q)
                CAL: begin
                    cal_acc_d = cal_sum;
                    cal_cnt_d = cal_cnt_q + 12'd1;
                    if (cal_cnt_q == CAL_LAST) begin
                        yaw_off_d  = 16'(cal_sum >>> CAL_SHIFT);
                        head_acc_d = '0;
                        state_d    = RUN;
                        cal_done_d = 1'b1;
                    end
                end
                RUN: begin
                    rdy_d = 1'b1;
                    if (moving) begin
                        head_acc_d = head_acc_q + {{11{comp[15]}}, comp} + fuse;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cal_cnt_q  <= '0;
            cal_acc_q  <= '0;
            yaw_off_q  <= '0;
            head_acc_q <= '0;
            cal_done_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cal_cnt_q  <= cal_cnt_d;
            cal_acc_q  <= cal_acc_d;
            yaw_off_q  <= yaw_off_d;
            head_acc_q <= head_acc_d;
            cal_done_q <= cal_done_d;
            rdy_q      <= rdy_d;
        end
    end

    assign heading  = head_acc_q[26:15];
    assign cal_done = cal_done_q;
    assign rdy      = rdy_q;

endmodule

// File: tb/tb_yaw_integrator.sv
// Scoreboard testbench for yaw_integrator: a plain-arithmetic reference model predicts every rdy/cal_done.
module tb_yaw_integrator;

    localparam int     N     = 256;
    localparam int     SHIFT = 8;
    localparam int     DB    = 4;
    localparam int     FG    = 512;
    localparam longint HMOD  = longint'(1) << 27;
    localparam int     M_IDLE = 0, M_CAL = 1, M_RUN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_cal = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] yaw_rt = 16'h0;
    logic        moving = 1'b0;
    logic        lftIR = 1'b0;
    logic        rghtIR = 1'b0;
    logic        cal_done;
    logic        rdy;
    logic [11:0] heading;

    yaw_integrator dut (
        .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .vld(vld), .yaw_rt(yaw_rt),
        .moving(moving), .lftIR(lftIR), .rghtIR(rghtIR),
        .cal_done(cal_done), .rdy(rdy), .heading(heading)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [11:0] h;
        int          cyc;
    } exp_t;

    exp_t rdy_q[$];
    int   cal_q[$];

    int     n_checks = 0;
    int     n_fail = 0;
    int     rdy_seen = 0;
    int     cal_seen = 0;

    int     mode = M_IDLE;
    longint sum = 0;
    int     cnt = 0;
    int     off = 0;
    longint head = 0;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] model_heading();
        return 12'((head >> 15) & 'hFFF);
    endfunction

    task automatic model_step(input bit s, input bit v, input logic [15:0] y,
                              input bit m, input bit l, input bit r);
        int   c;
        int   f;
        exp_t e;
        if (s) begin
            mode = M_CAL;
            sum  = 0;
            cnt  = 0;
        end else if (v) begin
            if (mode == M_CAL) begin
                sum += longint'($signed(y));
                cnt++;
                if (cnt == N) begin
                    off  = int'(shortint'(sum >>> SHIFT));
                    head = 0;
                    mode = M_RUN;
                    cal_q.push_back(cyc + 1);
                end
            end else if (mode == M_RUN) begin
                if (m) begin
                    c = int'($signed(y)) - off;
                    if (c > 32767) c = 32767;
                    if (c < -32768) c = -32768;
                    if (c > -DB && c < DB) c = 0;
                    f = 0;
`ifdef IR_FUSION_EN
                    if (l && !r) f = -FG;
                    else if (r && !l) f = FG;
`endif
                    head = (head + c + f) % HMOD;
                    if (head < 0) head += HMOD;
                end
                e.h   = model_heading();
                e.cyc = cyc + 1;
                rdy_q.push_back(e);
            end
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit s, input bit v, input logic [15:0] y,
                                 input bit m, input bit l, input bit r);
        strt_cal = s;
        vld      = v;
        yaw_rt   = y;
        moving   = m;
        lftIR    = l;
        rghtIR   = r;
        model_step(s, v, y, m, l, r);
        @(posedge clk);
        #1;
        strt_cal = 1'b0;
        vld      = 1'b0;
    endtask

    task automatic feed(input int n, input logic [15:0] y, input bit m, input bit l, input bit r);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, y, m, l, r);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
        end
    endtask

    task automatic feedRandom(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, 16'($urandom), 1'($urandom_range(0, 3) != 0),
                          1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
        end
    endtask

    task automatic calibrate(input logic [15:0] y);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        feed(N, y, 1'b0, 1'b0, 1'b0);
        idleCycles(3);
    endtask

    // Monitor: every rdy / cal_done must match the head of its queue, including the cycle it appears
    initial begin
        exp_t e;
        int   ec;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rdy) begin
                    rdy_seen++;
                    if (rdy_q.size() == 0) begin
                        checkOutput("rdy_unexpected", 1, 0);
                    end else begin
                        e = rdy_q.pop_front();
                        checkOutput("rdy_heading", heading, e.h);
                        checkOutput("rdy_latency", cyc, e.cyc);
                    end
                end
                if (cal_done) begin
                    cal_seen++;
                    if (cal_q.size() == 0) begin
                        checkOutput("cal_done_unexpected", 1, 0);
                    end else begin
                        ec = cal_q.pop_front();
                        checkOutput("cal_done_latency", cyc, ec);
                    end
                end
            end
        end
    end

    initial begin
        int          r0;
        logic [11:0] hold;

        #1;
        checkOutput("reset_heading", heading, 12'h000);
        checkOutput("reset_rdy", rdy, 0);
        checkOutput("reset_cal_done", cal_done, 0);
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(1);

        feed(5, 16'h1234, 1'b1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("idle_no_rdy", rdy_seen, 0);

        calibrate(16'h0010);
        checkOutput("cal_done_pulses", cal_seen, 1);
        checkOutput("heading_after_cal", heading, 12'h000);

        feed(50, 16'h0010, 1'b1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("zero_rate_rdy_count", rdy_seen, 50);
        checkOutput("zero_rate_heading", heading, 12'h000);

        feed(16, 16'h0810, 1'b1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("integrate_heading", heading, 12'h001);

        feed(16, 16'h0810, 1'b0, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("not_moving_heading", heading, 12'h001);
        checkOutput("not_moving_rdy_count", rdy_seen, 82);

        feed(8, 16'h0013, 1'b1, 1'b0, 1'b0);
        feed(8, 16'h000D, 1'b1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("deadband_heading", heading, 12'h001);
        feed(4, 16'h0014, 1'b1, 1'b0, 1'b0);
        feed(4, 16'h000C, 1'b1, 1'b0, 1'b0);

        feedRandom(150);
        idleCycles(3);

        calibrate(16'hFFF0);
        feed(64, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("saturation_heading", heading, 12'h03F);

`ifdef IR_FUSION_EN
        calibrate(16'hFFF0);
        feed(64, 16'hFFF0, 1'b1, 1'b1, 1'b0);
        idleCycles(2);
        checkOutput("fusion_left_heading", heading, 12'hFFF);
        feed(16, 16'hFFF0, 1'b1, 1'b1, 1'b1);
        idleCycles(2);
        checkOutput("fusion_both_heading", heading, 12'hFFF);
        feed(64, 16'hFFF0, 1'b1, 1'b0, 1'b1);
        idleCycles(2);
        checkOutput("fusion_right_heading", heading, 12'h000);
`endif

        feedRandom(200);
        feed(4, 16'h4000, 1'b1, 1'b0, 1'b0);
        idleCycles(3);
        hold = model_heading();
        r0   = rdy_seen;

        applyStimulus(1'b1, 1'b1, 16'h4000, 1'b1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("strt_cal_vld_no_rdy", rdy_seen, r0);
        feed(100, 16'h0100, 1'b1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("heading_hold_cal", heading, hold);
        checkOutput("no_rdy_in_cal", rdy_seen, r0);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midcal_reset_heading", heading, 12'h000);
        checkOutput("midcal_reset_rdy", rdy, 0);
        checkOutput("midcal_reset_cal_done", cal_done, 0);
        mode = M_IDLE;
        sum  = 0;
        cnt  = 0;
        off  = 0;
        head = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycles(1);

        r0 = cal_seen;
        feed(200, 16'h0010, 1'b1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("post_reset_idle_cal_done", cal_seen, r0);

        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b0, 1'b1, 16'($urandom_range(0, 255)) - 16'd128, 1'b0, 1'b0, 1'b0);
        end
        idleCycles(3);
        checkOutput("recal_cal_done_total", cal_seen, r0 + 1);
        feedRandom(60);
        idleCycles(4);

        checkOutput("rdy_queue_drained", rdy_q.size(), 0);
        checkOutput("cal_queue_drained", cal_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/yaw_integrator.md
Name: yaw_integrator

Overview:
- Downstream of the inertial sensor SPI interface. Consumes each assembled 16-bit yaw-rate sample (vld/yaw_rt) and calibrates out the gyro zero-rate offset.
- Integrates the compensated rate into a 12-bit robot heading, with guardrail IR fusion nudging drift.
- Produces heading/rdy for the heading-control PID stage.

Parameters:
- FAST_SIM, 1: calibration sample count N = 256 when 1, 2048 when 0; shift CAL_SHIFT = 8 / 11.
- DEADBAND, 4: |compensated rate| < DEADBAND is treated as 0.
- FUSION_GAIN, 512: magnitude added to or subtracted from the accumulator per fused sample.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- strt_cal  in  1  1-cycle pulse; starts offset calibration
- vld  in  1  1-cycle pulse; yaw_rt valid this cycle
- yaw_rt  in  16  signed raw yaw rate (CCW positive)
- moving  in  1  integrate only when 1
- lftIR  in  1  left guardrail hit
- rghtIR  in  1  right guardrail hit
- cal_done  out  1  1-cycle pulse; calibration complete
- rdy  out  1  1-cycle pulse; new heading valid
- heading  out  12  signed heading; 0x000 = original direction, 0x3FF = 90° CCW, 0x7FF = 180°

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; cal_cnt, cal_acc, yaw_off and head_acc all 0; cal_done = 0, rdy = 0, heading = 0.
- State machine (IDLE, CAL, RUN):
  - IDLE: vld is ignored. strt_cal -> CAL.
  - CAL: each vld adds sign-extended yaw_rt into 27-bit cal_acc and increments cal_cnt.
  - CAL exit: on the vld that makes the count N, yaw_off <= (cal_acc + yaw_rt) >>> CAL_SHIFT (arithmetic, truncated to 16 bits), head_acc <= 0, and the FSM moves to RUN. cal_done is registered and pulses the cycle after that vld.
  - RUN: each vld gives a registered update, with rdy pulsing exactly 1 cycle after vld. vld occurring in IDLE or CAL never produces rdy.
- strt_cal handling:
  - In any state it clears cal_acc and cal_cnt and goes to CAL.
  - It takes priority over a coincident vld; that sample is discarded.
  - During CAL it restarts calibration. heading holds its last value until calibration completes.
- Compensation: comp = yaw_rt − yaw_off, computed in 17 bits and saturated to signed 16 bits (0x7FFF / 0x8000). If |comp| < DEADBAND, comp = 0.
- Integration, in RUN on vld with moving = 1:
  - head_acc (27-bit, wraps modulo 2^27) += sext(comp) + fuse.
  - heading = head_acc[26:15], so heading wraps modulo 4096 naturally.
- moving = 0: head_acc is not updated, but rdy still pulses with the unchanged heading.
- Fusion term fuse:
  - lftIR only: −FUSION_GAIN (steer CW, away from the left rail).
  - rghtIR only: +FUSION_GAIN.
  - Both or neither: 0.
  - IR inputs are sampled only on the vld cycle.

Optional Feature:
- Macro IR_FUSION_EN.
- When defined: the fusion term is as specified above.
- When undefined: fuse is 0 and lftIR/rghtIR are unused. All other behaviour and timing are identical.

Test Plan:
- Reset -> heading = 0x000, rdy = 0, cal_done = 0. Send vld pulses in IDLE -> no rdy.
- Calibration: strt_cal, then 256 vld with yaw_rt = 0x0010 -> cal_done is a single pulse 1 cycle after the 256th vld. Then moving = 1 with 50 vld of yaw_rt = 0x0010 -> heading stays 0x000, rdy pulses 50 times.
- Integration: after the offset 0x0010 calibration, moving = 1 and 16 vld of yaw_rt = 0x0810 -> heading = 0x001. Then moving = 0 with 16 more vld -> heading stays 0x001.
- Deadband and saturation, two cases:
  - Offset 0x0010, yaw_rt = 0x0013 -> no change.
  - Recalibrate with yaw_rt = 0xFFF0 (offset −16), then 64 vld of 0x7FFF -> comp saturates to 0x7FFF, head_acc = 64 × 32767, heading = 0x03F.
- Fusion (IR_FUSION_EN defined): yaw_rt = offset, lftIR = 1 for 64 vld -> heading = 0xFFF. Next, lftIR = rghtIR = 1 -> no change. Then rghtIR = 1 only, 64 vld -> heading = 0x000.
- strt_cal coincident with a RUN vld -> no rdy, state CAL, heading holds until the new cal_done. Async reset mid-CAL -> all state cleared, heading = 0.
